// File: rtl/vga_sync_rx.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_rx
// Purpose  : VGA timing receiver. Samples active-low hsync/vsync once per
//            pixel clock, recovers column/row, checks the stream against the
//            configured mode and reports lock.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_rx #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] column,
  output logic [9:0] row,
  output logic       visible,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_error
);

  localparam int H_WHOLE = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_WHOLE = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_WHOLE - 1);
  localparam logic [9:0] V_LAST       = 10'(V_WHOLE - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam int FCW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [FCW-1:0] LOCK_COUNT = FCW'(LOCK_FRAMES);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Sampled sync levels and the previous samples used for edge detection
  logic h_q, v_q, h_p, v_p;

  logic [9:0]     column_q, column_d;
  logic [9:0]     row_q, row_d;
  logic [1:0]     state_q, state_d;
  logic [FCW-1:0] frames_q, frames_d;
  logic           hseen_q, hseen_d;
  logic           locked_q, locked_d;
  logic           visible_q, visible_d;
  logic           frame_start_q, frame_start_d;
  logic           sync_error_q, sync_error_d;

  logic           h_fall, v_fall, col_wrap, exp_h, exp_v, mismatch;
  logic [9:0]     col_pred, row_pred;
  logic [FCW-1:0] frames_inc;

  // Predict the position of the current sample, snap on sync edges and run the lock FSM
  always_comb begin
    h_fall   = !h_q && h_p;
    v_fall   = !v_q && v_p;
    col_wrap = (column_q == H_LAST);
    col_pred = col_wrap ? 10'd0 : column_q + 10'd1;
    row_pred = row_q;
    if (col_wrap) begin
      row_pred = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
    end

    // Expected levels use the unsnapped prediction, so a disagreeing snap is a mismatch
    exp_h    = !((col_pred >= H_SYNC_START) && (col_pred < H_SYNC_END));
    exp_v    = !((row_pred >= V_SYNC_START) && (row_pred < V_SYNC_END));
    mismatch = (h_q != exp_h) || (v_q != exp_v);

    column_d = h_fall ? H_SYNC_START : col_pred;
    row_d    = v_fall ? V_SYNC_START : row_pred;

    frames_inc   = frames_q + 1'b1;
    state_d      = state_q;
    frames_d     = frames_q;
    hseen_d      = hseen_q;
    sync_error_d = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        hseen_d = hseen_q | h_fall;
        if (v_fall && (hseen_q || h_fall)) begin
          state_d  = ST_VERIFY;
          frames_d = '0;
        end
      end
      ST_VERIFY: begin
        if (mismatch) begin
          sync_error_d = 1'b1;
          state_d      = ST_SEARCH;
          hseen_d      = 1'b0;
        end else if (v_fall) begin
          frames_d = frames_inc;
          if (frames_inc == LOCK_COUNT) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (mismatch) begin
          sync_error_d = 1'b1;
          state_d      = ST_SEARCH;
          hseen_d      = 1'b0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        hseen_d = 1'b0;
      end
    endcase

    // Lock-qualified flags follow the next state so loss of lock clears them at once
    locked_d      = (state_d == ST_LOCKED);
    visible_d     = locked_d && (column_d < H_VIS_END) && (row_d < V_VIS_END);
    frame_start_d = locked_d && (column_d == 10'd0) && (row_d == 10'd0);
  end

  // Register the sync samples, recovered position, FSM and output flags
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= 1'b1;
      v_q           <= 1'b1;
      h_p           <= 1'b1;
      v_p           <= 1'b1;
      column_q      <= '0;
      row_q         <= '0;
      state_q       <= ST_SEARCH;
      frames_q      <= '0;
      hseen_q       <= 1'b0;
      locked_q      <= 1'b0;
      visible_q     <= 1'b0;
      frame_start_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      h_q           <= hsync_in;
      v_q           <= vsync_in;
      h_p           <= h_q;
      v_p           <= v_q;
      column_q      <= column_d;
      row_q         <= row_d;
      state_q       <= state_d;
      frames_q      <= frames_d;
      hseen_q       <= hseen_d;
      locked_q      <= locked_d;
      visible_q     <= visible_d;
      frame_start_q <= frame_start_d;
      sync_error_q  <= sync_error_d;
    end
  end

  assign column      = column_q;
  assign row         = row_q;
  assign visible     = visible_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_error  = sync_error_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_rx
// Purpose  : Self-checking bench for vga_sync_rx using a reduced video mode.
//            A sync source model drives the receiver; per-sample expectations
//            are queued and compared one output cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_rx;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 3, VS = 2, VB = 3;
  localparam int LF = 2;
  localparam int HW = HV + HF + HS + HB;
  localparam int VW = VV + VF + VS + VB;
  localparam int FRAME = HW * VW;
  localparam int HSS = HV + HF, HSE = HV + HF + HS;
  localparam int VSS = VV + VF, VSE = VV + VF + VS;
  localparam int SRC_ROW = 4;

  localparam int INJ_NONE = 0, INJ_LOW = 1, INJ_MISS = 2, INJ_LONG = 3, INJ_RESET = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] column, row;
  logic       visible, locked, frame_start, sync_error;

  vga_sync_rx #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .column(column), .row(row), .visible(visible), .locked(locked),
    .frame_start(frame_start), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk_pos;
    int col;
    int row;
    bit lck;
    bit err;
    bit vis;
    bit fs;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_pass = 0, n_fail = 0;

  // source model and expectation tracker state
  int gcol = 0, grow = 0;
  bit src_en = 0, src_pending = 0, aligned = 0;
  bit trk_locked = 0, trk_hseen = 0;
  int trk_vf = 0;
  bit prev_h = 1, prev_v = 1;
  int inj_kind = INJ_NONE, inj_row = 0, inj_col = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t  e;
    string at;
    e  = sb.pop_front();
    at = $sformatf("@row%0d/col%0d", e.row, e.col);
    chk({"locked", at}, 32'(locked), 32'(e.lck));
    chk({"sync_error", at}, 32'(sync_error), 32'(e.err));
    chk({"visible", at}, 32'(visible), 32'(e.vis));
    chk({"frame_start", at}, 32'(frame_start), 32'(e.fs));
    if (e.chk_pos) begin
      chk({"column", at}, 32'(column), 32'(e.col));
      chk({"row", at}, 32'(row), 32'(e.row));
    end
  endtask

  // One pixel: check the oldest pending output, drive the next sample, queue its expectation
  task automatic step(input bit rst_now, input bit rst_gen);
    exp_t e;
    exp_t re;
    bit   do_rst, err_here, pos_ok, hf, vf;
    logic hs, vs;
    @(negedge clk);
    if (sb.size() == 2) check_out();

    if (gcol == HW - 1) begin
      gcol = 0;
      grow = (grow == VW - 1) ? 0 : grow + 1;
    end else begin
      gcol = gcol + 1;
    end
    if (src_pending && grow == SRC_ROW && gcol == 0) begin
      src_en      = 1;
      src_pending = 0;
    end

    do_rst = rst_now || (inj_kind == INJ_RESET && grow == inj_row && gcol == inj_col);
    if (do_rst && rst_gen) begin
      gcol = 1;
      grow = 0;
    end

    hs       = src_en ? !(gcol >= HSS && gcol < HSE) : 1'b1;
    vs       = src_en ? !(grow >= VSS && grow < VSE) : 1'b1;
    err_here = 0;
    pos_ok   = aligned;

    if (!do_rst) begin
      case (inj_kind)
        INJ_LOW: if (grow == inj_row && gcol == inj_col) begin
          hs = 1'b0; err_here = 1; pos_ok = 0; aligned = 0; inj_kind = INJ_NONE;
        end
        INJ_MISS: if (grow == inj_row) begin
          hs = 1'b1;
          if (gcol == HSS) err_here = 1;
          if (gcol == HW - 1) inj_kind = INJ_NONE;
        end
        INJ_LONG: if (grow == inj_row && gcol == HSE) begin
          hs = 1'b0; err_here = 1; inj_kind = INJ_NONE;
        end
        default: ;
      endcase
    end

    hsync_in = hs;
    vsync_in = vs;
    reset    = do_rst;

    if (do_rst) begin
      if (inj_kind == INJ_RESET) inj_kind = INJ_NONE;
      re.chk_pos = 1; re.col = 0; re.row = 0;
      re.lck = 0; re.err = 0; re.vis = 0; re.fs = 0;
      if (sb.size() == 1) sb[0] = re;
      else sb.push_back(re);
      aligned    = rst_gen;
      trk_locked = 0;
      trk_vf     = 0;
      trk_hseen  = 0;
      prev_h     = 1;
      prev_v     = 1;
      e.chk_pos = 1; e.col = 1; e.row = 0;
      e.lck = 0; e.err = 0; e.vis = 0; e.fs = 0;
    end else begin
      hf = prev_h && !hs;
      vf = prev_v && !vs;
      if (err_here) begin
        trk_locked = 0;
        trk_vf     = 0;
        trk_hseen  = 0;
      end else if (trk_vf == 0) begin
        if (vf && (trk_hseen || hf)) trk_vf = 1;
        else trk_hseen = trk_hseen || hf;
      end else if (vf && !trk_locked) begin
        trk_vf++;
        if (trk_vf == LF + 1) begin
          trk_locked = 1;
          aligned    = 1;
        end
      end
      prev_h = hs;
      prev_v = vs;
      e.chk_pos = pos_ok;
      e.col = gcol;
      e.row = grow;
      e.lck = trk_locked;
      e.err = err_here;
      e.vis = trk_locked && gcol < HV && grow < VV;
      e.fs  = trk_locked && gcol == 0 && grow == 0;
    end
    sb.push_back(e);
  endtask

  task automatic arm(input int kind, input int r, input int c);
    inj_kind = kind;
    inj_row  = r;
    inj_col  = c;
  endtask

  initial begin
    // reset, then idle inputs for two whole frames
    step(1, 1);
    repeat (2 * FRAME) step(0, 0);

    // source enabled from row SRC_ROW; lock on the third vsync fall, then three locked frames
    src_pending = 1;
    repeat (7 * FRAME) step(0, 0);

    // single-cycle hsync glitch while locked, then relock
    arm(INJ_LOW, 7, 5);
    repeat (5 * FRAME) step(0, 0);

    // whole line without hsync
    arm(INJ_MISS, 9, 0);
    repeat (5 * FRAME) step(0, 0);

    // hsync one cycle too long on one line
    arm(INJ_LONG, 6, HSE);
    repeat (5 * FRAME) step(0, 0);

    // receiver-only reset mid-frame
    arm(INJ_RESET, 8, 10);
    repeat (5 * FRAME) step(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_rx.md
# vga_sync_rx

VGA timing receiver: the consuming end of the active-low hsync/vsync stream produced by `vga_sync`. It samples hsync/vsync once per pixel clock, recovers the pixel column and row, verifies the stream against the configured mode, and reports lock. It sits at the input of capture/measurement paths, for example to validate generated sync or to align pixel data captured from an external VGA source in the same clock domain.

## Interface

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse lines
- V_BACK, 33, vertical back porch
- LOCK_FRAMES, 2, consecutive clean frames required before lock

Derived values: H_WHOLE = 800 and V_WHOLE = 525 with the defaults.

Ports:
- clk, input, 1, pixel clock; one pixel per cycle
- reset, input, 1, synchronous, active-high
- hsync_in, input, 1, active-low hsync, synchronous to clk
- vsync_in, input, 1, active-low vsync, synchronous to clk
- column, output, 10, recovered column, 0..H_WHOLE-1
- row, output, 10, recovered row, 0..V_WHOLE-1
- visible, output, 1, locked && column < H_VISIBLE && row < V_VISIBLE
- locked, output, 1, stream verified
- frame_start, output, 1, one-cycle pulse when locked and column==0 and row==0
- sync_error, output, 1, one-cycle pulse on any mismatch while in VERIFY or LOCKED

## Operation

- hsync_in and vsync_in are registered once, into h_q and v_q. The previous samples are held in h_p and v_p for edge detection.
- The prediction (column/row) is the value the counters would take for the current sample: column+1, wrapping at H_WHOLE-1 to 0. On a column wrap, row+1, wrapping at V_WHOLE-1 to 0.
- Snapping is active in every state:
  - hsync fall (h_q=0, h_p=1): column is forced to H_VISIBLE+H_FRONT (656).
  - vsync fall: row is forced to V_VISIBLE+V_FRONT (490).
  - If a vsync fall and a row increment occur in the same cycle, the snap wins.
- Expected levels are computed from the predicted position:
  - hsync is expected low iff column is in [656, 752).
  - vsync is expected low iff row is in [490, 492).
- A mismatch is any sample whose h_q or v_q differs from the expected level at the predicted position. Mismatches are evaluated only in VERIFY and LOCKED.
- State machine:
  - SEARCH: no checks, locked=0. Move to VERIFY on a vsync fall, provided at least one hsync fall has been seen since entering SEARCH. The frame counter clears.
  - VERIFY:
    - On a mismatch: sync_error pulses and the state returns to SEARCH.
    - Each vsync fall without a mismatch increments the frame counter.
    - When the counter reaches LOCK_FRAMES, the state moves to LOCKED.
  - LOCKED: on a mismatch, sync_error pulses and the state returns to SEARCH (locked=0).
- column and row free-run from reset even when there is no input activity. visible and frame_start stay 0 unless locked.

## Timing

- Latency is 1 cycle. Outputs after posedge n+1 describe the sample present at posedge n.
  - Example: if hsync_in is first low at posedge n, column==656 after posedge n+1.
- Reset values:
  - column=0, row=0, visible=0, locked=0, frame_start=0, sync_error=0.
  - State is SEARCH, the frame counter is 0, and h_p/v_p/h_q/v_q are 1.
- Reset asserted mid-frame: all of the above values apply after the next posedge, and no sync_error pulse is generated.
- Lock timing: locked rises in the same output cycle that reports row==490 for the vsync fall that makes the counter equal LOCK_FRAMES. That fall is the (LOCK_FRAMES+1)-th vsync fall after leaving SEARCH.
- Loss of lock: sync_error=1 and locked=0 in the same output cycle as the mismatching sample. In that cycle, visible=0 and frame_start=0.
- A snap that matches the prediction is not a mismatch. A snap that disagrees with the prediction is necessarily a mismatch, because the expected level differs.
- Missing hsync: the first sample at predicted column 656 that is still high is a mismatch.

## Test plan

- `vga_sync` (640x480 defaults) drives the receiver, with the source enabled starting at row 100. Required: locked=1 exactly at the output cycle for row 490 of the 3rd vsync fall. From then on, column/row equal the generator's column/row delayed by 1 cycle on every cycle for 3 frames, frame_start pulses once per frame, and sync_error never pulses.
- While locked, force hsync_in low for 1 cycle at column 100, row 200. Required: sync_error=1 for one cycle and locked=0 at output column 100/row 200. The receiver relocks at the 3rd subsequent vsync fall.
- While locked, suppress hsync for the whole of row 300. Required: sync_error pulses at output column 656, row 300.
- While locked, lengthen hsync to 97 cycles on one line. Required: sync_error pulses at output column 752 of that line.
- While locked, assert reset for 1 cycle at row 250, column 400. Required: all outputs are 0 after that posedge, no sync_error, and the receiver relocks after 3 vsync falls.
- hsync_in and vsync_in held high after reset for 2*H_WHOLE*V_WHOLE cycles. Required: column cycles 0..799, row increments at each wrap, and locked, visible, frame_start and sync_error all stay 0.
